// File: rtl/ramm_arbiter_pkg.sv
// Shared definitions for the ramm_arbiter slice: FSM states and port indices.
package ramm_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   localparam int unsigned PORT_M0 = 0;
   localparam int unsigned PORT_M1 = 1;

endpackage

// File: rtl/ramm_rr_arb2.sv
// Two-way round-robin arbiter; prio moves to the other port after every grant.
import ramm_arbiter_pkg::*;

module ramm_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   // prio_q = 0 favours m0, 1 favours m1
   logic prio_q;

   always_comb begin
      gnt = '0;
      if (en) begin
         if (req == 2'b11) begin
            gnt[PORT_M0] = ~prio_q;
            gnt[PORT_M1] = prio_q;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else if (gnt[PORT_M0]) begin
         prio_q <= 1'b1;
      end else if (gnt[PORT_M1]) begin
         prio_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ramm_arbiter.sv
// Shares one 16x32 distributed RAM between two requesters and runs a hardware
// clear sequence that fills every word with CLR_VALUE.
import ramm_arbiter_pkg::*;

module ramm_arbiter #(
   parameter int unsigned           ADDR_WIDTH = 4,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic [DATA_WIDTH-1:0] ram_di,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_do
);

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q;
   logic                    m0_rvalid_q, m1_rvalid_q;
   logic [DATA_WIDTH-1:0]   m0_rdata_q, m1_rdata_q;
   logic [1:0]              req, gnt;
   logic                    arb_en;
   logic                    m0_rd, m1_rd;

   // clr_start wins over any request, and reset forces every grant low
   assign req    = {m1_req, m0_req};
   assign arb_en = (state_q == ST_IDLE) && !rst && !clr_start;

   ramm_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .en  (arb_en),
      .gnt (gnt)
   );

   assign m0_gnt = gnt[PORT_M0];
   assign m1_gnt = gnt[PORT_M1];
   assign m0_rd  = m0_gnt && !m0_we;
   assign m1_rd  = m1_gnt && !m1_we;

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_raddr = '0;
      ram_di    = '0;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_di    = CLR_VALUE;
         end else if (m0_gnt) begin
            if (m0_we) begin
               ram_we    = 1'b1;
               ram_waddr = m0_addr;
               ram_di    = m0_wdata;
            end else begin
               ram_raddr = m0_addr;
            end
         end else if (m1_gnt) begin
            if (m1_we) begin
               ram_we    = 1'b1;
               ram_waddr = m1_addr;
               ram_di    = m1_wdata;
            end else begin
               ram_raddr = m1_addr;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clr_cnt_q <= '0;
               if (clr_start) begin
                  state_q <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt_q == CNT_LAST) begin
                  state_q   <= ST_IDLE;
                  clr_cnt_q <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               clr_cnt_q <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         m0_rvalid_q <= m0_rd;
         m1_rvalid_q <= m1_rd;
         if (m0_rd) begin
            m0_rdata_q <= ram_do;
         end
         if (m1_rd) begin
            m1_rdata_q <= ram_do;
         end
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ramm_arbiter.sv
// Directed bench for ramm_arbiter with a behavioural 16x32 RAM attached.
module tb_ramm_arbiter;

   logic        clk = 1'b0;
   logic        rst, clr_start;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, clr_busy, ram_we;
   logic [31:0] m0_rdata, m1_rdata, ram_di, ram_do;
   logic [3:0]  ram_waddr, ram_raddr;
   logic [31:0] mem [16];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_di;
   assign ram_do = mem[ram_raddr];

   ramm_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CLR_VALUE(32'h0)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .ram_di(ram_di), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_we(ram_we), .ram_do(ram_do)
   );

   typedef struct {
      logic        rst, clr;
      logic        r0, w0; logic [3:0] a0; logic [31:0] d0;
      logic        r1, w1; logic [3:0] a1; logic [31:0] d1;
      logic        g0, g1, we; logic [3:0] wa, ra; logic [31:0] di;
      logic        v0, v1; logic [31:0] q0, q1; logic busy;
   } vec_t;

   function automatic vec_t mk(
      logic rs, logic cl,
      logic r0, logic w0, logic [3:0] a0, logic [31:0] d0,
      logic r1, logic w1, logic [3:0] a1, logic [31:0] d1,
      logic g0, logic g1, logic we, logic [3:0] wa, logic [3:0] ra, logic [31:0] di,
      logic v0, logic v1, logic [31:0] q0, logic [31:0] q1, logic busy);
      vec_t v;
      v.rst = rs; v.clr = cl;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.we = we; v.wa = wa; v.ra = ra; v.di = di;
      v.v0 = v0; v.v1 = v1; v.q0 = q0; v.q1 = q1; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Drive on the falling edge, let combinational outputs settle before checking.
   task automatic drv(input logic rs, input logic cl,
                      input logic r0, input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [3:0] a1, input logic [31:0] d1);
      @(negedge clk);
      rst = rs; clr_start = cl;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      #1;
   endtask

   vec_t vt [19];

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hA0A0_0000 + i;

      vt[0]  = mk(1,0, 1,1,3,32'hDEADBEEF, 1,0,4,0, 0,0,0,0,0,0, 0,0,0,0,0);
      vt[1]  = mk(0,0, 1,1,3,32'hDEADBEEF, 0,0,0,0, 1,0,1,3,0,32'hDEADBEEF, 0,0,0,0,0);
      vt[2]  = mk(0,0, 1,0,3,0, 0,0,0,0, 1,0,0,0,3,0, 0,0,0,0,0);
      vt[3]  = mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 1,0,32'hDEADBEEF,0,0);
      vt[4]  = mk(0,0, 0,0,0,0, 1,0,0,0, 0,1,0,0,0,0, 0,0,32'hDEADBEEF,0,0);
      vt[5]  = mk(0,0, 1,0,1,0, 1,0,2,0, 1,0,0,0,1,0, 0,1,32'hDEADBEEF,32'hA0A00000,0);
      vt[6]  = mk(0,0, 1,0,1,0, 1,0,2,0, 0,1,0,0,2,0, 1,0,32'hA0A00001,32'hA0A00000,0);
      vt[7]  = mk(0,0, 1,0,1,0, 1,0,2,0, 1,0,0,0,1,0, 0,1,32'hA0A00001,32'hA0A00002,0);
      vt[8]  = mk(0,0, 1,0,1,0, 1,0,2,0, 0,1,0,0,2,0, 1,0,32'hA0A00001,32'hA0A00002,0);
      vt[9]  = mk(0,0, 1,0,1,0, 1,0,2,0, 1,0,0,0,1,0, 0,1,32'hA0A00001,32'hA0A00002,0);
      vt[10] = mk(0,0, 1,0,1,0, 1,0,2,0, 0,1,0,0,2,0, 1,0,32'hA0A00001,32'hA0A00002,0);
      vt[11] = mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,1,32'hA0A00001,32'hA0A00002,0);
      vt[12] = mk(0,0, 0,0,0,0, 1,1,9,32'h12345678, 0,1,1,9,0,32'h12345678, 0,0,32'hA0A00001,32'hA0A00002,0);
      vt[13] = mk(0,0, 1,0,9,0, 0,0,0,0, 1,0,0,0,9,0, 0,0,32'hA0A00001,32'hA0A00002,0);
      vt[14] = mk(0,0, 0,0,0,0, 1,0,1,0, 0,1,0,0,1,0, 1,0,32'h12345678,32'hA0A00002,0);
      vt[15] = mk(0,0, 0,0,0,0, 1,0,2,0, 0,1,0,0,2,0, 0,1,32'h12345678,32'hA0A00001,0);
      vt[16] = mk(0,0, 0,0,0,0, 1,0,3,0, 0,1,0,0,3,0, 0,1,32'h12345678,32'hA0A00002,0);
      vt[17] = mk(0,0, 0,0,0,0, 1,0,0,0, 0,1,0,0,0,0, 0,1,32'h12345678,32'hDEADBEEF,0);
      vt[18] = mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,1,32'h12345678,32'hA0A00000,0);

      drv(1,0, 0,0,0,0, 0,0,0,0);
      drv(1,0, 0,0,0,0, 0,0,0,0);

      for (int i = 0; i < 19; i++) begin
         drv(vt[i].rst, vt[i].clr, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
             vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
         chk($sformatf("v%0d m0_gnt", i), {31'b0, m0_gnt}, {31'b0, vt[i].g0});
         chk($sformatf("v%0d m1_gnt", i), {31'b0, m1_gnt}, {31'b0, vt[i].g1});
         chk($sformatf("v%0d ram_we", i), {31'b0, ram_we}, {31'b0, vt[i].we});
         chk($sformatf("v%0d ram_waddr", i), {28'b0, ram_waddr}, {28'b0, vt[i].wa});
         chk($sformatf("v%0d ram_raddr", i), {28'b0, ram_raddr}, {28'b0, vt[i].ra});
         chk($sformatf("v%0d ram_di", i), ram_di, vt[i].di);
         chk($sformatf("v%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, vt[i].v0});
         chk($sformatf("v%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, vt[i].v1});
         chk($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].q0);
         chk($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].q1);
         chk($sformatf("v%0d clr_busy", i), {31'b0, clr_busy}, {31'b0, vt[i].busy});
      end

      // clr_start collides with an m0 write: clear wins, write lands afterwards
      drv(0,1, 1,1,5,32'h55555555, 0,0,0,0);
      chk("clr0 m0_gnt", {31'b0, m0_gnt}, 32'd0);
      chk("clr0 ram_we", {31'b0, ram_we}, 32'd0);
      chk("clr0 busy", {31'b0, clr_busy}, 32'd0);
      for (int k = 0; k < 16; k++) begin
         drv(0,0, 1,1,5,32'h55555555, 0,0,0,0);
         chk($sformatf("clr%0d busy", k), {31'b0, clr_busy}, 32'd1);
         chk($sformatf("clr%0d m0_gnt", k), {31'b0, m0_gnt}, 32'd0);
         chk($sformatf("clr%0d ram_we", k), {31'b0, ram_we}, 32'd1);
         chk($sformatf("clr%0d ram_waddr", k), {28'b0, ram_waddr}, k);
         chk($sformatf("clr%0d ram_di", k), ram_di, 32'h0);
      end
      drv(0,0, 1,1,5,32'h55555555, 0,0,0,0);
      chk("post busy", {31'b0, clr_busy}, 32'd0);
      chk("post m0_gnt", {31'b0, m0_gnt}, 32'd1);
      chk("post ram_waddr", {28'b0, ram_waddr}, 32'd5);
      chk("post ram_di", ram_di, 32'h55555555);
      drv(0,0, 0,0,0,0, 1,0,15,0);
      chk("rd15 m1_gnt", {31'b0, m1_gnt}, 32'd1);
      drv(0,0, 1,0,5,0, 0,0,0,0);
      chk("rd15 m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
      chk("rd15 m1_rdata", m1_rdata, 32'h0);
      drv(0,0, 0,0,0,0, 0,0,0,0);
      chk("rd5 m0_rdata", m0_rdata, 32'h55555555);

      // Preload distinct values, then abort a clear when clr_cnt reaches 7
      for (int i = 0; i < 16; i++) begin
         drv(0,0, 1,1,i[3:0],32'hC0DE0000 + i, 0,0,0,0);
         chk($sformatf("pre%0d m0_gnt", i), {31'b0, m0_gnt}, 32'd1);
      end
      drv(0,1, 0,0,0,0, 0,0,0,0);
      for (int k = 0; k < 7; k++) begin
         drv(0,0, 0,0,0,0, 0,0,0,0);
         chk($sformatf("abt%0d ram_waddr", k), {28'b0, ram_waddr}, k);
      end
      drv(1,0, 1,1,0,32'hFFFFFFFF, 0,0,0,0);
      chk("abt rst ram_we", {31'b0, ram_we}, 32'd0);
      chk("abt rst m0_gnt", {31'b0, m0_gnt}, 32'd0);
      for (int i = 0; i <= 16; i++) begin
         drv(0,0, 0,0,0,0, (i < 16),0,i[3:0],0);
         if (i == 0) chk("abt busy", {31'b0, clr_busy}, 32'd0);
         if (i < 16) chk($sformatf("chk%0d m1_gnt", i), {31'b0, m1_gnt}, 32'd1);
         if (i > 0) begin
            chk($sformatf("chk%0d m1_rvalid", i - 1), {31'b0, m1_rvalid}, 32'd1);
            chk($sformatf("chk%0d m1_rdata", i - 1), m1_rdata,
                (i - 1 < 7) ? 32'h0 : 32'hC0DE0000 + (i - 1));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
